// File: rtl/median_filter_nch.sv
// N-channel 3x3 rank filter: two line buffers, 3x3 window, 3-stage sort network; 4-cycle latency.
// Optional MEDIAN_RANK_MODE_EN: honour mode (01 min, 10 max, else median) and build global min/max.
module median_filter_nch #(
  parameter int CH    = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int IMG_W = 640,
  parameter int X_W   = 10
) (
  input  logic                  vga_clk,
  input  logic                  rst,
  input  logic [X_W-1:0]        pixel_x,
  input  logic [X_W-1:0]        pixel_y,
  input  logic                  pix_vld,
  input  logic [CH*IN_W-1:0]    pix_in,
  input  logic [1:0]            mode,
  output logic [CH*OUT_W-1:0]   pix_out,
  output logic                  out_vld,
  output logic [X_W-1:0]        out_x,
  output logic [X_W-1:0]        out_y
);
  // pix_vld qualifies one pixel per cycle with no backpressure; out_vld is pix_vld delayed by 4 cycles.
  localparam int D_W = CH * IN_W;
  localparam int A_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  function automatic logic [IN_W-1:0] min2(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    return (a < b) ? a : b;
  endfunction
  function automatic logic [IN_W-1:0] max2(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    return (a < b) ? b : a;
  endfunction
  function automatic logic [IN_W-1:0] min3(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                                           input logic [IN_W-1:0] c);
    return min2(min2(a, b), c);
  endfunction
  function automatic logic [IN_W-1:0] max3(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                                           input logic [IN_W-1:0] c);
    return max2(max2(a, b), c);
  endfunction
  function automatic logic [IN_W-1:0] med3(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                                           input logic [IN_W-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic [D_W-1:0] line1_mem [IMG_W];
  logic [D_W-1:0] line2_mem [IMG_W];
  logic [A_W-1:0] addr;
  logic           in_range;
  logic           wr_en;
  logic [D_W-1:0] rd1, rd2;

  assign addr     = pixel_x[A_W-1:0];
  assign in_range = (32'(pixel_x) < IMG_W);
  assign wr_en    = pix_vld && in_range;
  assign rd1      = in_range ? line1_mem[addr] : '0;
  assign rd2      = in_range ? line2_mem[addr] : '0;

  // Read-before-write: the old row N-1 word moves down to row N-2.
  always_ff @(posedge vga_clk) begin
    if (wr_en) begin
      line1_mem[addr] <= pix_in;
      line2_mem[addr] <= line1_mem[addr];
    end
  end

  logic [1:0] rows_seen_q, rows_seen_d, cols_seen_q, cols_seen_d;
  logic       complete;
  logic [2:0][2:0][D_W-1:0] win_q, win_d;
  logic [2:0] vld_pipe_q, vld_pipe_d, cmp_pipe_q, cmp_pipe_d;
  logic [2:0][X_W-1:0] x_pipe_q, x_pipe_d, y_pipe_q, y_pipe_d;
  logic [CH-1:0][2:0][IN_W-1:0] sa_lo_q, sa_lo_d, sa_mid_q, sa_mid_d, sa_hi_q, sa_hi_d;
  logic [CH-1:0][IN_W-1:0] sb_maxlo_q, sb_maxlo_d, sb_medmid_q, sb_medmid_d, sb_minhi_q, sb_minhi_d;
  logic [CH*OUT_W-1:0] pix_out_q, pix_out_d;
  logic out_vld_q, out_vld_d;
  logic [X_W-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
  logic [IN_W-1:0] res;
`ifdef MEDIAN_RANK_MODE_EN
  logic [2:0][1:0] mode_pipe_q, mode_pipe_d;
  logic [CH-1:0][IN_W-1:0] sb_gmin_q, sb_gmin_d, sb_gmax_q, sb_gmax_d;
`else
  logic unused_mode;
  assign unused_mode = ^mode;
`endif

  always_comb begin
    rows_seen_d = rows_seen_q;
    cols_seen_d = cols_seen_q;
    win_d       = win_q;
    if (pix_vld) begin
      if (in_range && pixel_x == X_W'(IMG_W - 1) && rows_seen_q != 2'd2)
        rows_seen_d = rows_seen_q + 2'd1;
      if (pixel_x == '0) cols_seen_d = '0;
      else if (cols_seen_q != 2'd2) cols_seen_d = cols_seen_q + 2'd1;
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = {rd2, rd1, pix_in};
    end
    complete = pix_vld && in_range && rows_seen_q == 2'd2 && pixel_y >= X_W'(2) &&
               pixel_x >= X_W'(2) && cols_seen_d == 2'd2;
    vld_pipe_d = {vld_pipe_q[1:0], pix_vld};
    cmp_pipe_d = {cmp_pipe_q[1:0], complete};
    x_pipe_d   = {x_pipe_q[1:0], pixel_x};
    y_pipe_d   = {y_pipe_q[1:0], pixel_y};
`ifdef MEDIAN_RANK_MODE_EN
    mode_pipe_d = {mode_pipe_q[1:0], mode};
`endif
    out_vld_d = vld_pipe_q[2];
    out_x_d   = x_pipe_q[2];
    out_y_d   = y_pipe_q[2];
  end

  always_comb begin
    sa_lo_d     = '0;
    sa_mid_d    = '0;
    sa_hi_d     = '0;
    sb_maxlo_d  = '0;
    sb_medmid_d = '0;
    sb_minhi_d  = '0;
`ifdef MEDIAN_RANK_MODE_EN
    sb_gmin_d   = '0;
    sb_gmax_d   = '0;
`endif
    pix_out_d   = '0;
    res         = '0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 3; k++) begin
        sa_lo_d[c][k]  = min3(win_q[k][0][c*IN_W +: IN_W], win_q[k][1][c*IN_W +: IN_W],
                              win_q[k][2][c*IN_W +: IN_W]);
        sa_mid_d[c][k] = med3(win_q[k][0][c*IN_W +: IN_W], win_q[k][1][c*IN_W +: IN_W],
                              win_q[k][2][c*IN_W +: IN_W]);
        sa_hi_d[c][k]  = max3(win_q[k][0][c*IN_W +: IN_W], win_q[k][1][c*IN_W +: IN_W],
                              win_q[k][2][c*IN_W +: IN_W]);
      end
      sb_maxlo_d[c]  = max3(sa_lo_q[c][0], sa_lo_q[c][1], sa_lo_q[c][2]);
      sb_medmid_d[c] = med3(sa_mid_q[c][0], sa_mid_q[c][1], sa_mid_q[c][2]);
      sb_minhi_d[c]  = min3(sa_hi_q[c][0], sa_hi_q[c][1], sa_hi_q[c][2]);
`ifdef MEDIAN_RANK_MODE_EN
      sb_gmin_d[c]   = min3(sa_lo_q[c][0], sa_lo_q[c][1], sa_lo_q[c][2]);
      sb_gmax_d[c]   = max3(sa_hi_q[c][0], sa_hi_q[c][1], sa_hi_q[c][2]);
      case (mode_pipe_q[2])
        2'b01:   res = sb_gmin_q[c];
        2'b10:   res = sb_gmax_q[c];
        default: res = med3(sb_maxlo_q[c], sb_medmid_q[c], sb_minhi_q[c]);
      endcase
`else
      res = med3(sb_maxlo_q[c], sb_medmid_q[c], sb_minhi_q[c]);
`endif
      // Incomplete windows may hold stale RAM data, so they are forced to black.
      if (vld_pipe_q[2] && cmp_pipe_q[2]) pix_out_d[c*OUT_W +: OUT_W] = res[IN_W-1 -: OUT_W];
    end
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      rows_seen_q <= '0;
      cols_seen_q <= '0;
      win_q       <= '0;
      vld_pipe_q  <= '0;
      cmp_pipe_q  <= '0;
      x_pipe_q    <= '0;
      y_pipe_q    <= '0;
      sa_lo_q     <= '0;
      sa_mid_q    <= '0;
      sa_hi_q     <= '0;
      sb_maxlo_q  <= '0;
      sb_medmid_q <= '0;
      sb_minhi_q  <= '0;
`ifdef MEDIAN_RANK_MODE_EN
      mode_pipe_q <= '0;
      sb_gmin_q   <= '0;
      sb_gmax_q   <= '0;
`endif
      pix_out_q   <= '0;
      out_vld_q   <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      rows_seen_q <= rows_seen_d;
      cols_seen_q <= cols_seen_d;
      win_q       <= win_d;
      vld_pipe_q  <= vld_pipe_d;
      cmp_pipe_q  <= cmp_pipe_d;
      x_pipe_q    <= x_pipe_d;
      y_pipe_q    <= y_pipe_d;
      sa_lo_q     <= sa_lo_d;
      sa_mid_q    <= sa_mid_d;
      sa_hi_q     <= sa_hi_d;
      sb_maxlo_q  <= sb_maxlo_d;
      sb_medmid_q <= sb_medmid_d;
      sb_minhi_q  <= sb_minhi_d;
`ifdef MEDIAN_RANK_MODE_EN
      mode_pipe_q <= mode_pipe_d;
      sb_gmin_q   <= sb_gmin_d;
      sb_gmax_q   <= sb_gmax_d;
`endif
      pix_out_q   <= pix_out_d;
      out_vld_q   <= out_vld_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign pix_out = pix_out_q;
  assign out_vld = out_vld_q;
  assign out_x   = out_x_q;
  assign out_y   = out_y_q;
endmodule

// File: tb/tb_median_filter_nch.sv
// Directed bench for median_filter_nch on a 16-pixel-wide image, 8 rows per frame.
module tb_median_filter_nch;
  localparam int CH = 3, IN_W = 8, OUT_W = 4, IMG_W = 16, X_W = 10, ROWS = 8, GAP = 7;
`ifdef MEDIAN_RANK_MODE_EN
  localparam logic [11:0] EXP_MIN = 12'h000;
  localparam logic [11:0] EXP_MAX = 12'h888;
`else
  localparam logic [11:0] EXP_MIN = 12'h444;
  localparam logic [11:0] EXP_MAX = 12'h444;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [X_W-1:0] pixel_x, pixel_y, out_x, out_y;
  logic pix_vld, out_vld;
  logic [CH*IN_W-1:0] pix_in;
  logic [1:0] mode;
  logic [CH*OUT_W-1:0] pix_out;

  int total = 0;
  int bad = 0;
  int cur_frame = 0;
  int got_frame [0:15][0:31];
  logic [11:0] got_mem [0:15][0:31];
  logic [3:0] hist_v;
  logic [9:0] hist_x [0:3];
  logic [9:0] hist_y [0:3];
  int lat;
  logic seen;

  median_filter_nch #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .IMG_W(IMG_W), .X_W(X_W)) dut (
    .vga_clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_vld(pix_vld),
    .pix_in(pix_in), .mode(mode), .pix_out(pix_out), .out_vld(out_vld), .out_x(out_x), .out_y(out_y)
  );

  // scoreboard: out_vld and tags must equal the inputs presented 4 cycles earlier
  always @(negedge clk) begin
    if (rst) begin
      hist_v = '0;
    end else begin
      total++;
      assert (out_vld === hist_v[3]) else begin
        bad++;
        $error("FAIL out_vld_timing: got %b want %b", out_vld, hist_v[3]);
      end
      if (hist_v[3]) begin
        total++;
        assert ({out_x, out_y} === {hist_x[3], hist_y[3]}) else begin
          bad++;
          $error("FAIL out_tag: got (%0d,%0d) want (%0d,%0d)", out_x, out_y, hist_x[3], hist_y[3]);
        end
      end
      if (out_vld && out_y < 16 && out_x < 32) begin
        got_mem[out_y[3:0]][out_x[4:0]] = pix_out;
        got_frame[out_y[3:0]][out_x[4:0]] = cur_frame;
      end
      hist_v = {hist_v[2:0], pix_vld};
      for (int i = 3; i > 0; i--) begin
        hist_x[i] = hist_x[i-1];
        hist_y[i] = hist_y[i-1];
      end
      hist_x[0] = pixel_x;
      hist_y[0] = pixel_y;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive(input int x, input int y, input logic [23:0] p, input logic [1:0] m);
    @(posedge clk); #1;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    pix_in  = p;
    mode    = m;
    pix_vld = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pix_vld = 1'b0;
    end
  endtask

  function automatic logic [23:0] pat(input int kind, input int x, input int y);
    logic [7:0] v;
    case (kind)
      0: return 24'h808080;
      1: return (x == 5 && y == 5) ? 24'hFFFFFF : 24'h404040;
      2: begin
        if (x >= 4 && x <= 6 && y >= 4 && y <= 6) begin
          v = 8'(((y - 4) * 3 + (x - 4)) * 16);
          return {v, v, v};
        end
        return 24'h404040;
      end
      default: begin
        v = (x == 5 && y == 5) ? 8'hE0 : 8'h20;
        return {v, 8'h0F, 8'hF0};
      end
    endcase
  endfunction

  task automatic row(input int kind, input int y, input int x0, input int x1, input logic [1:0] m);
    for (int x = x0; x <= x1; x++) begin
      drive(x, y, pat(kind, x, y), m);
      if (kind == 1 && x == 8) idle(3);
    end
  endtask

  task automatic frame(input int kind, input logic [1:0] m, input logic oor);
    cur_frame++;
    for (int y = 0; y < ROWS; y++) begin
      row(kind, y, 0, IMG_W - 1, m);
      if (oor && y == 3) drive(IMG_W, 3, 24'h000000, m);
      idle(GAP);
    end
    idle(8);
  endtask

  task automatic check_tag(input string tag, input int x, input int y, input logic [11:0] exp);
    total++;
    assert (got_frame[y][x] == cur_frame && got_mem[y][x] === exp) else begin
      bad++;
      $error("FAIL %s: tag (%0d,%0d) got %h in frame %0d, want %h in frame %0d",
             tag, x, y, got_mem[y][x], got_frame[y][x], exp, cur_frame);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pix_vld = 1'b0; pixel_x = '0; pixel_y = '0; pix_in = '0; mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_pix_out", 32'(pix_out), 32'h0);
    check_val("reset_out_vld", 32'(out_vld), 32'h0);
    check_val("reset_out_x", 32'(out_x), 32'h0);
    check_val("reset_out_y", 32'(out_y), 32'h0);
    rst = 1'b0;
    idle(3);

    // single pixel latency
    drive(0, 0, 24'h808080, 2'b00);
    idle(1);
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (out_vld) seen = 1'b1;
    end
    check_val("latency", 32'(lat), 32'd4);
    check_val("latency_pix", 32'(pix_out), 32'h0);
    idle(4);

    // flat field with an out-of-range pixel at the end of row 3
    frame(0, 2'b00, 1'b1);
    check_tag("flat_row0", 5, 0, 12'h000);
    check_tag("flat_row1", 5, 1, 12'h000);
    check_tag("flat_col0", 0, 2, 12'h000);
    check_tag("flat_col1", 1, 5, 12'h000);
    check_tag("flat_first", 2, 2, 12'h888);
    check_tag("flat_mid", 9, 4, 12'h888);
    check_tag("flat_last", 15, 7, 12'h888);
    check_tag("flat_oor", 16, 3, 12'h000);

    // salt impulse with mid-line blanking
    frame(1, 2'b00, 1'b0);
    check_tag("salt_ylow", 8, 1, 12'h000);
    check_tag("salt_55", 5, 5, 12'h444);
    check_tag("salt_66", 6, 6, 12'h444);
    check_tag("salt_77", 7, 7, 12'h444);
    check_tag("salt_75", 7, 5, 12'h444);
    check_tag("salt_57", 5, 7, 12'h444);
    check_tag("salt_25", 2, 5, 12'h444);

    // ramp window under each rank mode
    frame(2, 2'b00, 1'b0);
    check_tag("ramp_median", 6, 6, 12'h444);
    frame(2, 2'b11, 1'b0);
    check_tag("ramp_mode11", 6, 6, 12'h444);
    frame(2, 2'b01, 1'b0);
    check_tag("ramp_min", 6, 6, EXP_MIN);
    frame(2, 2'b10, 1'b0);
    check_tag("ramp_max", 6, 6, EXP_MAX);

    // channel independence
    frame(3, 2'b00, 1'b0);
    check_tag("chan_66", 6, 6, 12'h20F);
    check_tag("chan_33", 3, 3, 12'h20F);
    check_tag("chan_edge", 1, 6, 12'h000);

    // reset in the middle of row 4
    cur_frame++;
    for (int y = 0; y < 4; y++) begin
      row(0, y, 0, IMG_W - 1, 2'b00);
      idle(GAP);
    end
    row(0, 4, 0, 7, 2'b00);
    @(posedge clk); #1;
    check_val("pre_rst_pix", 32'(pix_out), 32'h888);
    rst = 1'b1;
    pix_vld = 1'b0;
    #1;
    check_val("rst_out_vld", 32'(out_vld), 32'h0);
    check_val("rst_pix_out", 32'(pix_out), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    row(0, 4, 8, IMG_W - 1, 2'b00);
    idle(GAP);
    for (int y = 5; y < ROWS; y++) begin
      row(0, y, 0, IMG_W - 1, 2'b00);
      idle(GAP);
    end
    idle(8);
    check_tag("rst_row4", 10, 4, 12'h000);
    check_tag("rst_row5", 15, 5, 12'h000);
    check_tag("rst_row6_col1", 1, 6, 12'h000);
    check_tag("rst_row6_col2", 2, 6, 12'h888);
    check_tag("rst_row7", 12, 7, 12'h888);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
